// File: rtl/apb_pkg.sv
// Shared APB types and default widths for the multi-slave APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2
  } apb_master_state_t;

  typedef struct packed {
    logic addr_err;
    logic tout_err;
    logic slv_err;
  } apb_xfer_err_t;

  localparam int APB_DEF_ADDR_WIDTH = 8;
  localparam int APB_DEF_DATA_WIDTH = 32;
  localparam int APB_DEF_NUM_SLAVES = 4;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts consecutive wait-state cycles; pulses expired on the cycle the limit is hit.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;

  // Saturates at the limit so the counter never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_cnt <= '0;
    else if (i_clear)              r_cnt <= '0;
    else if (i_en && r_cnt != MAX) r_cnt <= r_cnt + CW'(1);
  end

  // Combinational so the abort lands right after the limiting wait cycle.
  assign o_expired = (TIMEOUT_CYCLES != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/apb_master_nslv.sv
// Request/response to APB bridge for NUM_SLAVES slaves with decode, slave-error and timeout reporting.
module apb_master_nslv
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DEF_DATA_WIDTH,
  parameter int NUM_SLAVES     = APB_DEF_NUM_SLAVES,
  parameter int SLV_ADDR_WIDTH = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [2:0]                       rsp_err,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic                             PWRITE,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  apb_master_state_t r_state, w_next;

  logic                      r_req_ready;
  logic                      r_rsp_valid;
  logic [DATA_WIDTH-1:0]     r_rsp_rdata;
  apb_xfer_err_t             r_rsp_err;
  logic [ADDR_WIDTH-1:0]     r_paddr;
  logic [DATA_WIDTH-1:0]     r_pwdata;
  logic                      r_pwrite;
  logic [NUM_SLAVES-1:0]     r_psel;
  logic                      r_penable;
  logic [SLV_ADDR_WIDTH-1:0] r_idx;

  logic [SLV_ADDR_WIDTH-1:0] w_idx;
  logic                      w_idx_ok;
  logic [NUM_SLAVES-1:0]     w_onehot;
  logic                      w_acc;
  logic                      w_pready;
  logic                      w_pslverr;
  logic [DATA_WIDTH-1:0]     w_prdata;
  logic                      w_expired;

  assign w_idx    = req_addr[ADDR_WIDTH-1 -: SLV_ADDR_WIDTH];
  assign w_idx_ok = ({1'b0, w_idx} < (SLV_ADDR_WIDTH + 1)'(NUM_SLAVES));
  assign w_acc    = req_valid && r_req_ready;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_dec
    assign w_onehot[g] = (w_idx == SLV_ADDR_WIDTH'(g));
  end

  // Only the selected slave's response lines are looked at.
  always_comb begin
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    w_prdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_idx == SLV_ADDR_WIDTH'(i)) begin
        w_pready  = PREADY[i];
        w_pslverr = PSLVERR[i];
        w_prdata  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_clk     (PCLK),
    .i_rst_n   (PRESETn),
    .i_clear   (w_acc && w_idx_ok),
    .i_en      ((r_state == ENABLE) && !w_pready),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc && w_idx_ok) w_next = SETUP;
      SETUP:   w_next = ENABLE;
      ENABLE:  if (w_pready || w_expired) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= '0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_idx       <= '0;
    end else begin
      r_req_ready <= (w_next == IDLE);
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= '0;
      case (r_state)
        IDLE: if (w_acc) begin
          if (w_idx_ok) begin
            r_paddr  <= req_addr;
            r_pwdata <= req_wdata;
            r_pwrite <= req_write;
            r_idx    <= w_idx;
            r_psel   <= w_onehot;
          end else begin
            r_rsp_valid        <= 1'b1;
            r_rsp_err.addr_err <= 1'b1;
          end
        end
        SETUP: r_penable <= 1'b1;
        ENABLE: if (w_pready || w_expired) begin
          r_psel      <= '0;
          r_penable   <= 1'b0;
          r_rsp_valid <= 1'b1;
          // A completing slave beats a timeout expiring in the same cycle.
          if (w_pready) begin
            r_rsp_err.slv_err <= w_pslverr;
            if (!r_pwrite && !w_pslverr) r_rsp_rdata <= w_prdata;
          end else begin
            r_rsp_err.tout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PWRITE    = r_pwrite;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;

endmodule
